// File: rtl/serial_deframer_pkg.sv
// Shared types, width helpers and default parameters for the serial deframer.
package serial_deframer_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      CHECK  = 2'd3
   } state_t;

   localparam int         DEF_SYNC_W   = 8;
   localparam logic [7:0] DEF_SYNC_PAT = 8'hA5;
   localparam int         DEF_DATA_W   = 8;
   localparam int         DEF_MAX_MISS = 2;

   // Width of an index running 0..n-1 (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter running 0..n.
   function automatic int cnt_w(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/serial_deframer_window.sv
// Sync-pattern window: SYNC_W-bit shift register with a saturating fill count
// and a combinational compare against the pattern including the incoming bit.
module deframer_window
   import serial_deframer_pkg::*;
#(
   parameter int                SYNC_W   = DEF_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic din,
   output logic match
);

   localparam int            FW   = cnt_w(SYNC_W);
   localparam logic [FW-1:0] FULL = FW'(SYNC_W);

   logic [SYNC_W-1:0] window;
   logic [SYNC_W-1:0] win_next;
   logic [FW-1:0]     fill;
   logic [FW-1:0]     fill_next;

   assign win_next  = (window << 1) | SYNC_W'(din);
   assign fill_next = (fill == FULL) ? FULL : fill + FW'(1);

   // The incoming bit counts toward the fill, so a match needs SYNC_W real
   // bits and never leans on zeros left in the window by a clear.
   assign match = (fill_next == FULL) && (win_next == SYNC_PAT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         window <= '0;
         fill   <= '0;
      end else if (en) begin
         window <= win_next;
         fill   <= fill_next;
      end
   end

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for SYNC_PAT, frames DATA_W-bit words, flywheel lock.
// Optional even-parity bit per frame with SERIAL_DEFRAMER_PARITY_EN.
module serial_deframer
   import serial_deframer_pkg::*;
#(
   parameter int                SYNC_W   = DEF_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT),
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                MAX_MISS = DEF_MAX_MISS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              idata,
   input  logic              ivalid,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid,
   output logic              locked,
   output logic              sync_err
`ifdef SERIAL_DEFRAMER_PARITY_EN
   ,
   output logic              operr
`endif
);

   localparam int            MAXB   = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
   localparam int            CW     = idx_w(MAXB);
   localparam int            MW     = idx_w(MAX_MISS);
   localparam logic [CW-1:0] LAST_D = CW'(DATA_W - 1);
   localparam logic [CW-1:0] LAST_S = CW'(SYNC_W - 1);
   localparam logic [MW-1:0] LAST_M = MW'(MAX_MISS - 1);

   state_t            state;
   logic [CW-1:0]     bit_cnt;
   logic [MW-1:0]     miss_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] dnext;
   logic              win_match;
   logic              win_clr;

   assign dnext = (shreg << 1) | DATA_W'(idata);

   // Dropping lock flushes the window so the hunt restarts from a clean slate.
   assign win_clr = ivalid && (state == CHECK) && (bit_cnt == LAST_S) &&
                    !win_match && (miss_cnt == LAST_M);

   deframer_window #(
      .SYNC_W   (SYNC_W),
      .SYNC_PAT (SYNC_PAT)
   ) u_window (
      .clk   (clk),
      .rst   (rst),
      .en    (ivalid),
      .clr   (win_clr),
      .din   (idata),
      .match (win_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         odata    <= '0;
         ovalid   <= 1'b0;
         locked   <= 1'b0;
         sync_err <= 1'b0;
         bit_cnt  <= '0;
         miss_cnt <= '0;
         shreg    <= '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
         operr    <= 1'b0;
`endif
      end else begin
         ovalid   <= 1'b0;
         sync_err <= 1'b0;
         if (ivalid) begin
            case (state)
               HUNT: begin
                  if (win_match) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg <= dnext;
                  if (bit_cnt == LAST_D) begin
                     bit_cnt <= '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                     state   <= PARITY;
`else
                     odata   <= dnext;
                     ovalid  <= 1'b1;
                     state   <= CHECK;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               PARITY: begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                  odata   <= shreg;
                  operr   <= ^{shreg, idata};
                  ovalid  <= 1'b1;
                  bit_cnt <= '0;
                  state   <= CHECK;
`else
                  state   <= HUNT;
`endif
               end
               CHECK: begin
                  if (bit_cnt == LAST_S) begin
                     bit_cnt <= '0;
                     if (win_match) begin
                        miss_cnt <= '0;
                        locked   <= 1'b1;
                        state    <= DATA;
                     end else begin
                        sync_err <= 1'b1;
                        if (miss_cnt == LAST_M) begin
                           miss_cnt <= '0;
                           locked   <= 1'b0;
                           state    <= HUNT;
                        end else begin
                           miss_cnt <= miss_cnt + MW'(1);
                           state    <= DATA;
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule
